// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: encodings, FSM states and
// small decode helpers used by the transmitter and its FIFO.
package uart_pkg;

    localparam int unsigned MIN_DIV = 2;
    localparam int unsigned BYTE_W  = 8;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_e;

    typedef enum logic [1:0] {
        DLEN_5 = 2'b00,
        DLEN_6 = 2'b01,
        DLEN_7 = 2'b10,
        DLEN_8 = 2'b11
    } dlen_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // Per-frame configuration, captured when a byte is popped.
    typedef struct packed {
        dlen_e   dlen;
        parity_e parity;
        logic    stop2;
    } frame_cfg_t;

    function automatic logic [BYTE_W-1:0] data_mask(input dlen_e dlen);
        logic [BYTE_W-1:0] m;
        case (dlen)
            DLEN_5:  m = 8'h1F;
            DLEN_6:  m = 8'h3F;
            DLEN_7:  m = 8'h7F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Index of the final data bit: 4 for 5 bits .. 7 for 8 bits.
    function automatic logic [2:0] last_idx(input dlen_e dlen);
        return {1'b0, dlen} + 3'd4;
    endfunction

    function automatic logic parity_on(input parity_e p);
        return (p == PAR_EVEN) || (p == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter: registered count and flags,
// first-word-fall-through read data.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    output logic [BYTE_W-1:0] rd_data_c,
    output logic              empty,
    output logic              ready,
    output logic [AW:0]       count
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count_d;
    logic              do_push;
    logic              do_pop;

    // Guards make overflow and underflow impossible regardless of the caller.
    assign do_push   = push && ready;
    assign do_pop    = pop && !empty;
    assign rd_data_c = mem[rd_ptr];

    always_comb begin
        count_d = count;
        case ({do_push, do_pop})
            2'b10:   count_d = count + (AW+1)'(1);
            2'b01:   count_d = count - (AW+1)'(1);
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            ready  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_d;
            empty <= (count_d == '0);
            ready <= (count_d != (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-fed, LSB-first framing with per-frame
// divisor, data length, parity and stop-bit configuration.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIV_W-1:0]   baud_div,
    input  logic [1:0]         cfg_data_bits,
    input  logic [1:0]         cfg_parity,
    input  logic               cfg_stop2,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               tx,
    output logic               tx_busy,
    output logic               tx_done,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam frame_cfg_t CFG_RST = '{dlen: DLEN_8, parity: PAR_NONE, stop2: 1'b0};

    state_e            state_q;
    state_e            state_d;
    logic [DIV_W-1:0]  cnt_q;
    logic [DIV_W-1:0]  cnt_d;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_d;
    logic [2:0]        idx_q;
    logic [2:0]        idx_d;
    logic [BYTE_W-1:0] shift_q;
    logic [BYTE_W-1:0] shift_d;
    frame_cfg_t        cfg_q;
    frame_cfg_t        cfg_d;
    logic              tx_d;
    logic              busy_d;
    logic              done_d;

    logic              push_c;
    logic              pop_c;
    logic              start_c;
    logic              bit_end_c;
    logic              fifo_empty;
    logic [BYTE_W-1:0] fifo_rd_data_c;
    logic [DIV_W-1:0]  eff_div_c;
    frame_cfg_t        cfg_in_c;

    assign push_c    = in_valid && in_ready;
    assign eff_div_c = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;
    assign bit_end_c = (cnt_q == div_q - DIV_W'(1));
    assign cfg_in_c  = '{dlen: dlen_e'(cfg_data_bits), parity: parity_e'(cfg_parity),
                         stop2: cfg_stop2};

    uart_tx_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data (in_data),
        .pop       (pop_c),
        .rd_data_c (fifo_rd_data_c),
        .empty     (fifo_empty),
        .ready     (in_ready),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state, frame datapath and next registered line/status values.
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end_c ? '0 : cnt_q + DIV_W'(1);
        div_d   = div_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        cfg_d   = cfg_q;
        done_d  = 1'b0;
        pop_c   = 1'b0;
        start_c = 1'b0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                start_c = !fifo_empty;
            end
            ST_START: begin
                if (bit_end_c) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end_c) begin
                    if (idx_q == last_idx(cfg_q.dlen)) begin
                        state_d = parity_on(cfg_q.parity) ? ST_PARITY : ST_STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end_c) begin
                    state_d = ST_STOP;
                    idx_d   = '0;
                end
            end
            ST_STOP: begin
                if (bit_end_c) begin
                    if (cfg_q.stop2 && (idx_q == 3'd0)) begin
                        idx_d = 3'd1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                        start_c = !fifo_empty;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Frame start: pop and snapshot byte and configuration together.
        if (start_c) begin
            pop_c   = 1'b1;
            state_d = ST_START;
            cnt_d   = '0;
            idx_d   = '0;
            div_d   = eff_div_c;
            cfg_d   = cfg_in_c;
            shift_d = fifo_rd_data_c & data_mask(cfg_in_c.dlen);
        end

        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[idx_d];
            ST_PARITY: tx_d = (^shift_q) ^ (cfg_q.parity == PAR_ODD);
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            div_q   <= DIV_W'(MIN_DIV);
            idx_q   <= '0;
            shift_q <= '0;
            cfg_q   <= CFG_RST;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            cfg_q   <= cfg_d;
            tx      <= tx_d;
            tx_busy <= busy_d;
            tx_done <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: framing, parity, stop bits, FIFO
// back-pressure, back-to-back frames, divisor clamping and mid-frame reset.
module tb_uart_tx_param;

    localparam int unsigned DIV_W   = 16;
    localparam int unsigned FIFO_AW = 2;
    localparam int TR_N = 2048;

    logic               clk = 1'b0;
    logic               rst;
    logic [DIV_W-1:0]   baud_div;
    logic [1:0]         cfg_data_bits;
    logic [1:0]         cfg_parity;
    logic               cfg_stop2;
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic               tx;
    logic               tx_busy;
    logic               tx_done;
    logic [FIFO_AW:0]   fifo_count;

    int checks;
    int errors;

    uart_tx_param #(
        .DIV_W   (DIV_W),
        .FIFO_AW (FIFO_AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .baud_div      (baud_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .tx            (tx),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    // Free-running trace of outputs, sampled 1 time unit after each rising edge.
    logic             tr_tx   [TR_N];
    logic             tr_busy [TR_N];
    logic             tr_done [TR_N];
    logic             tr_rdy  [TR_N];
    logic [FIFO_AW:0] tr_cnt  [TR_N];
    int scnt = 0;

    always @(posedge clk) begin
        #1;
        tr_tx[11'(scnt)]   = tx;
        tr_busy[11'(scnt)] = tx_busy;
        tr_done[11'(scnt)] = tx_done;
        tr_rdy[11'(scnt)]  = in_ready;
        tr_cnt[11'(scnt)]  = fifo_count;
        scnt = scnt + 1;
    end

    int base;
    int len;

    function automatic logic s_tx(input int k);   return tr_tx[11'(base + k)];   endfunction
    function automatic logic s_busy(input int k); return tr_busy[11'(base + k)]; endfunction
    function automatic logic s_done(input int k); return tr_done[11'(base + k)]; endfunction
    function automatic logic s_rdy(input int k);  return tr_rdy[11'(base + k)];  endfunction
    function automatic logic [FIFO_AW:0] s_cnt(input int k); return tr_cnt[11'(base + k)]; endfunction

    function automatic int first_busy();
        for (int k = 0; k < len; k++) if (s_busy(k)) return k;
        return -1;
    endfunction

    function automatic int first_not_ready();
        for (int k = 0; k < len; k++) if (!s_rdy(k)) return k;
        return -1;
    endfunction

    function automatic int count_busy();
        int n = 0;
        for (int k = 0; k < len; k++) if (s_busy(k)) n++;
        return n;
    endfunction

    function automatic int count_done();
        int n = 0;
        for (int k = 0; k < len; k++) if (s_done(k)) n++;
        return n;
    endfunction

    function automatic int count_tx_low();
        int n = 0;
        for (int k = 0; k < len; k++) if (!s_tx(k)) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rec_start();
        base = scnt;
    endtask

    task automatic push(input logic [7:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait for the line to go busy and then fully idle, with a cycle budget.
    task automatic wait_idle(input string tag, input int maxc);
        int  n    = 0;
        bit  seen = 0;
        bit  fin  = 0;
        while (!fin && n < maxc) begin
            @(negedge clk);
            n++;
            if (tx_busy) seen = 1;
            else if (seen && fifo_count == '0) fin = 1;
        end
        chk({tag, "_idle_reached"}, 32'(fin), 32'd1);
        repeat (2) @(negedge clk);
        len = scnt - base;
    endtask

    task automatic frame_check(input string tag, input int f, input logic [15:0] bits,
                               input int nb, input int div);
        int bad = 0;
        for (int i = 0; i < nb * div; i++) if (s_tx(f + i) !== bits[i / div]) bad++;
        chk({tag, "_wave"}, 32'(bad), 32'd0);
        chk({tag, "_done_pos"}, 32'(s_done(f + nb * div)), 32'd1);
    endtask

    task automatic single(input string tag, input logic [15:0] bits, input int nb, input int div);
        int f;
        f = first_busy();
        chk({tag, "_latency"}, 32'(f), 32'd1);
        frame_check(tag, f, bits, nb, div);
        chk({tag, "_busy_len"}, 32'(count_busy()), 32'(nb * div));
        chk({tag, "_n_done"}, 32'(count_done()), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int f;
        int r0;
        logic rdy;
        logic [7:0] b;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        baud_div = 16'd4;
        cfg_data_bits = 2'b11;
        cfg_parity = 2'b00;
        cfg_stop2 = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", 32'(in_ready), 32'd1);
        chk("rel_tx", 32'(tx), 32'd1);

        // 8N1, divisor 4, 0xA5: 0,1,0,1,0,0,1,0,1,1
        rec_start();
        push(8'hA5);
        wait_idle("a5", 200);
        single("a5_8n1", 16'h034A, 10, 4);

        // 7E1, divisor 3: 0x07 and 0x87 share the waveform 0,1,1,1,0,0,0,0,1,1
        baud_div = 16'd3;
        cfg_data_bits = 2'b10;
        cfg_parity = 2'b01;
        rec_start();
        push(8'h07);
        wait_idle("07", 200);
        single("07_7e1", 16'h030E, 10, 3);
        rec_start();
        push(8'h87);
        wait_idle("87", 200);
        single("87_7e1", 16'h030E, 10, 3);

        // 8O2, divisor 2, 0x03; config scrambled mid-frame must not matter
        baud_div = 16'd2;
        cfg_data_bits = 2'b11;
        cfg_parity = 2'b10;
        cfg_stop2 = 1'b1;
        rec_start();
        push(8'h03);
        repeat (5) @(negedge clk);
        baud_div = 16'd7;
        cfg_data_bits = 2'b00;
        cfg_parity = 2'b00;
        cfg_stop2 = 1'b0;
        wait_idle("03", 200);
        single("03_8o2", 16'h0E06, 12, 2);

        // Back-pressure: in_valid held high, divisor 16, 8N1
        baud_div = 16'd16;
        cfg_data_bits = 2'b11;
        cfg_parity = 2'b00;
        cfg_stop2 = 1'b0;
        rec_start();
        acc = 0;
        in_data = 8'h10;
        in_valid = 1'b1;
        repeat (12) begin
            rdy = in_ready;
            @(negedge clk);
            if (rdy) begin
                acc++;
                in_data = 8'h10 + 8'(acc);
            end
        end
        in_valid = 1'b0;
        chk("fill_accepted", 32'(acc), 32'd5);
        wait_idle("fill", 1200);
        f = first_busy();
        chk("fill_latency", 32'(f), 32'd1);
        for (int k = 0; k < 5; k++) begin
            b = 8'h10 + 8'(k);
            frame_check($sformatf("fill_b%0d", k), f + 160 * k, {6'b0, 1'b1, b, 1'b0}, 10, 16);
        end
        chk("fill_busy_len", 32'(count_busy()), 32'd800);
        chk("fill_n_done", 32'(count_done()), 32'd5);
        r0 = first_not_ready();
        chk("fill_full_count", 32'(s_cnt(r0)), 32'd4);
        chk("fill_rdy_before_done", 32'(s_rdy(f + 159)), 32'd0);
        chk("fill_rdy_at_done", 32'(s_rdy(f + 160)), 32'd1);
        chk("fill_count_at_done", 32'(s_cnt(f + 160)), 32'd3);

        // Reset during DATA bit 3 with two bytes queued
        baud_div = 16'd4;
        in_valid = 1'b1;
        in_data = 8'h11;
        @(negedge clk);
        in_data = 8'h22;
        @(negedge clk);
        in_data = 8'h33;
        @(negedge clk);
        in_valid = 1'b0;
        chk("abort_queued", 32'(fifo_count), 32'd2);
        repeat (16) @(negedge clk);
        chk("abort_busy_pre", 32'(tx_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(tx_busy), 32'd0);
        chk("abort_count", 32'(fifo_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rec_start();
        chk("abort_ready", 32'(in_ready), 32'd1);
        repeat (60) @(negedge clk);
        len = scnt - base;
        chk("abort_no_busy", 32'(count_busy()), 32'd0);
        chk("abort_no_low", 32'(count_tx_low()), 32'd0);
        chk("abort_no_done", 32'(count_done()), 32'd0);

        // Divisor 0 and 1 clamp to 2; 5N1 0x15 -> 0,1,0,1,0,1,1
        baud_div = 16'd0;
        cfg_data_bits = 2'b00;
        rec_start();
        push(8'h15);
        wait_idle("div0", 100);
        single("div0_5n1", 16'h006A, 7, 2);
        baud_div = 16'd1;
        rec_start();
        push(8'hF5);
        wait_idle("div1", 100);
        single("div1_5n1", 16'h006A, 7, 2);

        // Push and pop in the same cycle leave the count unchanged
        baud_div = 16'd2;
        cfg_data_bits = 2'b11;
        rec_start();
        in_data = 8'h5A;
        in_valid = 1'b1;
        @(negedge clk);
        chk("pp_count_first", 32'(fifo_count), 32'd1);
        in_data = 8'hC3;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pp_count_same", 32'(fifo_count), 32'd1);
        wait_idle("pp", 200);
        f = first_busy();
        chk("pp_latency", 32'(f), 32'd1);
        frame_check("pp_5a", f, {6'b0, 1'b1, 8'h5A, 1'b0}, 10, 2);
        frame_check("pp_c3", f + 20, {6'b0, 1'b1, 8'hC3, 1'b0}, 10, 2);
        chk("pp_busy_len", 32'(count_busy()), 32'd40);
        chk("pp_n_done", 32'(count_done()), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter: a second-generation serial TX for the design's UART path.
- Accepts bytes over a valid/ready stream into a small internal FIFO.
- Serialises them LSB-first with runtime-selectable baud divisor, data length (5–8), parity mode and 1/2 stop bits.
- Sits between a host/bus-side byte producer and the tx pin; back-to-back frames run with no idle gap.

Parameters:
- DIV_W, 16, width of baud divisor input (bit period in clk cycles).
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW (default 4).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- baud_div  in  DIV_W  clk cycles per bit; values 0 and 1 treated as 2
- cfg_data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits
- cfg_parity  in  2  00=none, 01=even, 10=odd, 11=none (reserved)
- cfg_stop2  in  1  0=one stop bit, 1=two stop bits
- in_data  in  8  byte to send; bits above the data length are ignored
- in_valid  in  1  producer has a byte
- in_ready  out  1  FIFO not full
- tx  out  1  serial line, idle high
- tx_busy  out  1  frame in progress (START through last STOP)
- tx_done  out  1  one-cycle pulse at end of last stop bit
- fifo_count  out  FIFO_AW+1  bytes queued, not yet started

Behaviour:
- Reset (async, immediate): tx=1, tx_busy=0, tx_done=0, in_ready=1 after release, fifo_count=0. FSM goes to IDLE; FIFO is cleared. A reset mid-frame aborts the frame; the line returns high at once.
- Handshake: push on posedge when in_valid && in_ready. in_ready = !full (registered count). A full FIFO never overwrites; in_data must stay stable while in_valid && !in_ready.
- Baud counter: counts 0..eff_div-1. The last count ends the current bit. The counter is reset to 0 at every frame start.
- baud_div and cfg_* are latched at frame start (the pop). Changes mid-frame have no effect until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1, busy=0. If FIFO is non-empty: pop, latch byte and config, go to START.
  - START: tx=0 for one bit period, then DATA with bit index 0.
  - DATA: tx=shift[idx]. At bit end: idx+1; after bit N-1 (N = 5..8), go to PARITY if parity is enabled, else STOP.
  - PARITY: even → tx = XOR of the N data bits; odd → tx = its inverse. One bit period, then STOP.
  - STOP: tx=1 for 1 or 2 bit periods.
  - At the end of STOP: pulse tx_done. If the FIFO is non-empty, pop and go directly to START (no idle cycle); else go to IDLE.
- Latency: a byte accepted at edge E into an empty FIFO with FSM in IDLE is popped at E+1. tx falls after edge E+1; tx_busy rises at the same edge.
- Simultaneous push and pop: both take effect; fifo_count is unchanged.
- Frame length = (1 + N + P + S) × eff_div cycles.
- tx and tx_busy are registered outputs; no combinational path from in_* to tx.

Decomposition:
- Shared package uart_pkg: parity encodings (PAR_NONE, PAR_EVEN, PAR_ODD), data-length encoding, FSM state enum, and the MIN_DIV=2 constant.
- One sub-module, uart_tx_fifo: synchronous FIFO (FIFO_AW, 8-bit data) with push/pop, full/empty and count, async reset.
- The FSM, baud counter and shifter live in the top.

Test Plan:
- baud_div=4, 8N1, push 0xA5 → tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. tx_done pulses at cycle 40 after the fall. busy is high for exactly 40 cycles.
- baud_div=3, 7 bits, even parity, push 0x07 → data 1,1,1,0,0,0,0, parity 1, stop 1. Frame is 30 cycles. Bit 7 of the input is ignored (0x87 gives an identical waveform).
- baud_div=2, 8 bits, odd parity, two stops, push 0x03 → parity bit 1, two stop bits, frame 24 cycles. Change cfg mid-frame → current frame unaffected.
- FIFO_AW=2, baud_div=16, in_valid held high from IDLE → exactly 5 bytes accepted. in_ready falls with fifo_count=4 and rises after the first tx_done. All 5 bytes are sent back-to-back with no high cycle between STOP and START.
- Assert rst during DATA bit 3 with 2 bytes queued → tx=1, busy=0, fifo_count=0 immediately. After release, in_ready=1 and no residual frame is sent.
- baud_div=0 and 1 → each bit lasts 2 cycles. Push and pop in the same cycle → fifo_count is unchanged.
